uart_tx_scheduler: RTL and testbench

Shares one UART transmitter (and its baud-rate generator) between NUM_REQ byte sources using round-robin arbitration. Sequences each frame with a start/busy handshake and enforces an inter-frame gap counted in baud ticks. Changes baud_select only while the link is idle, so no frame is ever sent at mixed rates. Sits between the byte producers and the transmitter/baud-rate-generator pair.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and baud-rate codes for the UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } sched_state_e;

    localparam logic [2:0] BAUD_300    = 3'd0;
    localparam logic [2:0] BAUD_1200   = 3'd1;
    localparam logic [2:0] BAUD_4800   = 3'd2;
    localparam logic [2:0] BAUD_9600   = 3'd3;
    localparam logic [2:0] BAUD_19200  = 3'd4;
    localparam logic [2:0] BAUD_38400  = 3'd5;
    localparam logic [2:0] BAUD_57600  = 3'd6;
    localparam logic [2:0] BAUD_115200 = 3'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ. The pointer itself lives in the scheduler.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       win_valid
);

    localparam int PTR_W = $clog2(NUM_REQ);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // Scan from the farthest offset down so the nearest asserted request wins last.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[wrap_add(rr_ptr, off)]) begin
                win_idx   = wrap_add(rr_ptr, off);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter with start/busy handshake, baud-tick
// inter-frame gap and idle-only baud changes. Optional WAIT_BUSY timeout: UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter int         DATA_W         = 8,
    parameter int         GAP_TICKS      = 2,
    parameter logic [2:0] DEFAULT_BAUD   = BAUD_115200,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      cfg_valid,
    input  logic [2:0]                cfg_baud,
    output logic [2:0]                baud_select,
    input  logic                      tx_tick,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic                      sched_busy,
    output logic                      err_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    sched_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [2:0]          baud_q, baud_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                cfg_pending_q, cfg_pending_d;
    logic [2:0]          cfg_value_q, cfg_value_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [PTR_W-1:0]    win_idx;
    logic                win_valid;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .win_idx  (win_idx),
        .win_valid(win_valid)
    );

    always_comb begin
        state_d       = state_q;
        gnt_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        baud_d        = baud_q;
        rr_ptr_d      = rr_ptr_q;
        cfg_pending_d = cfg_pending_q;
        cfg_value_d   = cfg_value_q;
        gap_d         = gap_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            // A pending baud change takes the idle cycle ahead of any request.
            IDLE: begin
                if (cfg_pending_q) begin
                    baud_d        = cfg_value_q;
                    cfg_pending_d = 1'b0;
                end else if (win_valid) begin
                    gnt_d     = NUM_REQ'(1) << win_idx;
                    tx_data_d = req_data[win_idx*DATA_W +: DATA_W];
                    rr_ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
                    state_d   = START;
                end
            end
            START: begin
                tx_start_d = 1'b1;
                state_d    = WAIT_BUSY;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                to_cnt_d   = '0;
`endif
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (GAP_TICKS == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d   = GAP_W'(GAP_TICKS);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else if (tx_tick) begin
                    gap_d = gap_q - GAP_W'(1);
                    if (gap_q == GAP_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Captured in every state after the idle clear so a fresh strobe is never lost.
        if (cfg_valid) begin
            cfg_pending_d = 1'b1;
            cfg_value_d   = cfg_baud;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            baud_q        <= DEFAULT_BAUD;
            rr_ptr_q      <= '0;
            cfg_pending_q <= 1'b0;
            cfg_value_q   <= '0;
            gap_q         <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt_q      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            baud_q        <= baud_d;
            rr_ptr_q      <= rr_ptr_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_value_q   <= cfg_value_d;
            gap_q         <= gap_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign baud_select = baud_q;
    assign sched_busy  = (state_q != IDLE) || cfg_pending_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler with a simple transmitter
// model (20-cycle busy) and a free-running baud tick every 4 cycles.
module tb_uart_tx_scheduler;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int GAP_TICKS = 2;
   localparam int BUSY_LEN  = 20;

   logic                      Clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic                      cfg_valid;
   logic [2:0]                cfg_baud;
   logic [2:0]                baud_select;
   logic                      tx_tick = 1'b0;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_start;
   logic                      tx_busy = 1'b0;
   logic                      sched_busy;
   logic                      err_timeout;

   int assertCount = 0;
   int failCount = 0;
   int startCount = 0;
   int ticksSinceDone = 100;
   int busyCnt = 0;
   int tickCnt = 0;
   logic prevBusy = 1'b0;
   logic txModelEn = 1'b1;
   logic [NUM_REQ-1:0] g;
   logic [7:0] srcData [NUM_REQ] = '{8'h11, 8'h22, 8'hA5, 8'h4C};

   uart_tx_scheduler #(
      .NUM_REQ(NUM_REQ),
      .DATA_W(DATA_W),
      .GAP_TICKS(GAP_TICKS),
      .DEFAULT_BAUD(3'b111),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .Clk(Clk),
      .reset(reset),
      .req(req),
      .req_data(req_data),
      .gnt(gnt),
      .cfg_valid(cfg_valid),
      .cfg_baud(cfg_baud),
      .baud_select(baud_select),
      .tx_tick(tx_tick),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .tx_busy(tx_busy),
      .sched_busy(sched_busy),
      .err_timeout(err_timeout)
   );

   // 50 MHz system clock
   always #10 Clk = ~Clk;

   // Baud tick: one-cycle pulse every fourth cycle, changed on the falling edge
   always @(negedge Clk) begin
      tickCnt = (tickCnt + 1) % 4;
      tx_tick = (tickCnt == 0);
   end

   // Transmitter model: busy rises the cycle after tx_start and lasts BUSY_LEN cycles
   always @(negedge Clk or posedge reset) begin
      if (reset) begin
         tx_busy = 1'b0;
         busyCnt = 0;
      end else if (busyCnt > 0) begin
         busyCnt = busyCnt - 1;
         if (busyCnt == 0) tx_busy = 1'b0;
      end else if (tx_start && txModelEn) begin
         tx_busy = 1'b1;
         busyCnt = BUSY_LEN;
      end
   end

   // Counts the ticks the scheduler can act on after the transmitter finishes
   always @(posedge Clk or posedge reset) begin
      if (reset) begin
         ticksSinceDone = 100;
         prevBusy = 1'b0;
      end else begin
         if (prevBusy && !tx_busy) ticksSinceDone = 0;
         else if (tx_tick) ticksSinceDone = ticksSinceDone + 1;
         prevBusy = tx_busy;
      end
   end

   // Every start pulse must be preceded by the full inter-frame gap
   always @(negedge Clk) begin
      if (!reset && tx_start) begin
         startCount = startCount + 1;
         checkOutput("gap_before_start", 32'(ticksSinceDone >= GAP_TICKS), 32'd1);
      end
   end

   // Global guard so a stuck DUT cannot hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, observed running, expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount = assertCount + 1;
      if (observed !== expected) begin
         failCount = failCount + 1;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
      req = r;
   endtask

   task automatic applyReset();
      @(negedge Clk);
      reset = 1'b1;
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic waitGrant(input string tag, output logic [NUM_REQ-1:0] seen);
      seen = '0;
      for (int i = 0; i < 300 && seen == '0; i++) begin
         @(negedge Clk);
         seen = gnt;
      end
      checkOutput(tag, 32'(seen != '0), 32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (sched_busy && n < 500);
      checkOutput(tag, 32'(sched_busy), 32'd0);
   endtask

   task automatic waitTxBusy(input string tag);
      int n;
      n = 0;
      while (!tx_busy && n < 100) begin
         @(negedge Clk);
         n++;
      end
      checkOutput(tag, 32'(tx_busy), 32'd1);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      req = '0;
      req_data = {srcData[3], srcData[2], srcData[1], srcData[0]};
      cfg_valid = 1'b0;
      cfg_baud = 3'b000;

      // Reset and idle values
      repeat (3) @(negedge Clk);
      checkOutput("rst_baud_in_reset", 32'(baud_select), 32'h7);
      reset = 1'b0;
      repeat (2) @(negedge Clk);
      checkOutput("idle_baud", 32'(baud_select), 32'h7);
      checkOutput("idle_gnt", 32'(gnt), 32'h0);
      checkOutput("idle_tx_start", 32'(tx_start), 32'h0);
      checkOutput("idle_tx_data", 32'(tx_data), 32'h0);
      checkOutput("idle_sched_busy", 32'(sched_busy), 32'h0);
      checkOutput("idle_err", 32'(err_timeout), 32'h0);

      // Single requester 2: grant latency, data, start pulse, gap of two ticks
      startCount = 0;
      applyStimulus(4'b0100);
      @(negedge Clk);
      checkOutput("t2_gnt", 32'(gnt), 32'h4);
      checkOutput("t2_data", 32'(tx_data), 32'hA5);
      checkOutput("t2_start_early", 32'(tx_start), 32'h0);
      applyStimulus(4'b0000);
      @(negedge Clk);
      checkOutput("t2_gnt_pulse", 32'(gnt), 32'h0);
      checkOutput("t2_start", 32'(tx_start), 32'h1);
      @(negedge Clk);
      checkOutput("t2_start_pulse", 32'(tx_start), 32'h0);
      waitIdle("t2_idle");
      checkOutput("t2_gap_ticks", 32'(ticksSinceDone), 32'd2);
      checkOutput("t2_start_count", 32'(startCount), 32'd1);
      checkOutput("t2_data_hold", 32'(tx_data), 32'hA5);

      // All requesters held: rotation 0,1,2,3,0,1,2,3 from a fresh pointer
      applyReset();
      startCount = 0;
      applyStimulus(4'b1111);
      for (int f = 0; f < 8; f++) begin
         waitGrant("t3_grant_seen", g);
         checkOutput("t3_rr_order", 32'(g), 32'h1 << (f % 4));
         checkOutput("t3_data", 32'(tx_data), 32'(srcData[f % 4]));
      end
      applyStimulus(4'b0000);
      waitIdle("t3_idle");
      checkOutput("t3_start_count", 32'(startCount), 32'd8);

      // Baud change mid-frame: last strobe wins, applied only once idle
      applyStimulus(4'b0010);
      waitGrant("t4_grant_seen", g);
      checkOutput("t4_gnt", 32'(g), 32'h2);
      applyStimulus(4'b1000);
      waitTxBusy("t4_tx_busy");
      cfg_valid = 1'b1;
      cfg_baud = 3'b011;
      @(negedge Clk);
      cfg_valid = 1'b0;
      checkOutput("t4_sched_busy", 32'(sched_busy), 32'h1);
      repeat (3) @(negedge Clk);
      cfg_valid = 1'b1;
      cfg_baud = 3'b001;
      @(negedge Clk);
      cfg_valid = 1'b0;
      checkOutput("t4_baud_hold", 32'(baud_select), 32'h7);
      n = 0;
      while (baud_select == 3'b111 && n < 300) begin
         @(negedge Clk);
         n++;
      end
      checkOutput("t4_baud_new", 32'(baud_select), 32'h1);
      checkOutput("t4_cfg_priority", 32'(gnt), 32'h0);
      checkOutput("t4_idle_at_cfg", 32'(sched_busy), 32'h0);
      @(negedge Clk);
      checkOutput("t4_pending_gnt", 32'(gnt), 32'h8);
      checkOutput("t4_pending_data", 32'(tx_data), 32'h4C);
      applyStimulus(4'b0000);
      waitIdle("t4_idle");

      // Reset during WAIT_DONE: immediate reset values, regrant from index 0
      applyStimulus(4'b0011);
      waitGrant("t5_grant_seen", g);
      checkOutput("t5_first_gnt", 32'(g), 32'h1);
      waitTxBusy("t5_tx_busy");
      repeat (3) @(negedge Clk);
      reset = 1'b1;
      #1;
      checkOutput("t5_rst_gnt", 32'(gnt), 32'h0);
      checkOutput("t5_rst_tx_data", 32'(tx_data), 32'h0);
      checkOutput("t5_rst_baud", 32'(baud_select), 32'h7);
      checkOutput("t5_rst_sched_busy", 32'(sched_busy), 32'h0);
      repeat (2) @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
      checkOutput("t5_regrant", 32'(gnt), 32'h1);
      checkOutput("t5_regrant_data", 32'(tx_data), 32'h11);
      applyStimulus(4'b0000);
      waitIdle("t5_idle");

`ifdef UART_TX_SCHED_TIMEOUT_EN
      // Transmitter never responds: timeout after 16 WAIT_BUSY cycles
      txModelEn = 1'b0;
      applyStimulus(4'b0001);
      waitGrant("to_grant_seen", g);
      applyStimulus(4'b0000);
      repeat (16) @(negedge Clk);
      checkOutput("to_not_yet", 32'(err_timeout), 32'h0);
      @(negedge Clk);
      checkOutput("to_err", 32'(err_timeout), 32'h1);
      checkOutput("to_idle", 32'(sched_busy), 32'h0);
      txModelEn = 1'b1;
      applyStimulus(4'b0100);
      waitGrant("to_regrant_seen", g);
      checkOutput("to_regrant", 32'(g), 32'h4);
      applyStimulus(4'b0000);
      waitIdle("to_idle_after");
      checkOutput("to_sticky", 32'(err_timeout), 32'h1);
`else
      checkOutput("err_tied_low", 32'(err_timeout), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
